// File: rtl/video_timing_pkg.sv
// Shared video timing defaults, sizing helpers and RGB565 expansion
// for the frame-buffer scan-out path.
package video_timing_pkg;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb888_t;

   // One delayed raster sample travelling alongside its SRAM read.
   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } raster_tap_t;

   localparam raster_tap_t IDLE_TAP = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

   function automatic int total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   // Replicate the MSBs into the low bits so full-scale 565 maps to 8'hFF.
   function automatic rgb888_t rgb565_expand(input logic [15:0] d);
      rgb888_t px;
      px.r = {d[15:11], d[15:13]};
      px.g = {d[10:5],  d[10:9]};
      px.b = {d[4:0],   d[4:2]};
      return px;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster h/v counters with raw syncs, active flag and frame-wrap pulse,
// advancing only on pixel-enable ticks.
module vga_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter int HW       = clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
   parameter int VW       = clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_en,
   output logic [HW-1:0] h,
   output logic [VW-1:0] v,
   output logic          active,
   output logic          hs_raw,
   output logic          vs_raw,
   output logic          frame_wrap
);

   localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   logic h_last, v_last;

   assign h_last = (h == HW'(H_TOTAL - 1));
   assign v_last = (v == VW'(V_TOTAL - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         h <= '0;
         v <= '0;
      end else if (pix_en) begin
         if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   always_comb begin
      active     = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
      hs_raw     = !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
      vs_raw     = !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));
      frame_wrap = pix_en && !reset && h_last && v_last;
   end

endmodule

// File: rtl/vga_frame_reader.sv
// SRAM frame-buffer scan-out: issues pixel reads ahead of the beam and
// realigns syncs with the returning RGB565 data.
module vga_frame_reader
   import video_timing_pkg::*;
#(
   parameter int                H_ACTIVE = DEF_H_ACTIVE,
   parameter int                H_FP     = DEF_H_FP,
   parameter int                H_SYNC   = DEF_H_SYNC,
   parameter int                H_BP     = DEF_H_BP,
   parameter int                V_ACTIVE = DEF_V_ACTIVE,
   parameter int                V_FP     = DEF_V_FP,
   parameter int                V_SYNC   = DEF_V_SYNC,
   parameter int                V_BP     = DEF_V_BP,
   parameter int                ADDR_W   = 20,
   parameter logic [ADDR_W-1:0] FB_BASE  = '0,
   parameter int                RD_LAT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pix_en,
   input  logic              scale2x,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [15:0]       rd_data,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank_n,
   output logic [7:0]        vga_r,
   output logic [7:0]        vga_g,
   output logic [7:0]        vga_b,
   output logic              frame_start
);

   localparam int HW = clog2(total(H_ACTIVE, H_FP, H_SYNC, H_BP));
   localparam int VW = clog2(total(V_ACTIVE, V_FP, V_SYNC, V_BP));
   localparam int XB = clog2(H_ACTIVE);

   logic [HW-1:0]     h;
   logic [VW-1:0]     v;
   logic              active, hs_raw, vs_raw;
   logic              scale_q;
   logic [ADDR_W-1:0] xs, ys, addr_calc, addr_q;
   raster_tap_t       pipe [RD_LAT];
   raster_tap_t       tap;
   rgb888_t           px;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HW(HW), .VW(VW)
   ) u_timing (
      .clk        (clk),
      .reset      (reset),
      .pix_en     (pix_en),
      .h          (h),
      .v          (v),
      .active     (active),
      .hs_raw     (hs_raw),
      .vs_raw     (vs_raw),
      .frame_wrap (frame_start)
   );

   always_comb begin
      xs        = scale_q ? ADDR_W'(h >> 1) : ADDR_W'(h);
      ys        = scale_q ? ADDR_W'(v >> 1) : ADDR_W'(v);
      addr_calc = FB_BASE + (ys << XB) + xs;
      rd_req    = pix_en && !reset && active;
      rd_addr   = rd_req ? addr_calc : addr_q;
      tap       = pipe[RD_LAT-1];
      px        = rgb565_expand(rd_data);
   end

   // Mode only changes at the top-left tick so a frame never mixes scales.
   always_ff @(posedge clk) begin
      if (reset) begin
         scale_q <= 1'b0;
         addr_q  <= FB_BASE;
      end else if (pix_en) begin
         if (rd_req) addr_q <= addr_calc;
         if (h == '0 && v == '0) scale_q <= scale2x;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= IDLE_TAP;
      end else if (pix_en) begin
         pipe[0] <= '{active: active, hs: hs_raw, vs: vs_raw};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
      end else if (pix_en) begin
         vga_hs      <= tap.hs;
         vga_vs      <= tap.vs;
         vga_blank_n <= tap.active;
         vga_r       <= tap.active ? px.r : 8'h00;
         vga_g       <= tap.active ? px.g : 8'h00;
         vga_b       <= tap.active ? px.b : 8'h00;
      end
   end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Randomized scan-out bench: a small raster checked every clock against a
// position-indexed reference model and a latency-RD_LAT SRAM model.
module tb_vga_frame_reader;

   localparam int HA = 16, HF = 2, HS = 3, HB = 3;
   localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam int AW = 8;
   localparam int FB = 8'hF0;
   localparam int RL = 2;
   localparam int XB = 4;

   logic          clk = 1'b0;
   logic          reset, pix_en, scale2x;
   logic          rd_req, vga_hs, vga_vs, vga_blank_n, frame_start;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;
   logic [7:0]    vga_r, vga_g, vga_b;

   logic [15:0]   mem [256];
   logic [AW-1:0] apipe [RL];

   typedef struct packed {
      bit act;
      bit hs;
      bit vs;
      int addr;
   } rec_t;

   rec_t hist[$];
   int   n, last_addr, n_assert, n_fail;
   bit   mode, armed;

   always #5 clk = ~clk;

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .ADDR_W(AW), .FB_BASE(AW'(FB)), .RD_LAT(RL)
   ) dut (
      .clk(clk), .reset(reset), .pix_en(pix_en), .scale2x(scale2x),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .frame_start(frame_start)
   );

   // SRAM: data for an address appears RL enabled ticks after it was presented.
   always @(posedge clk) begin
      if (pix_en) begin
         apipe[0] <= rd_addr;
         for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
      end
   end
   assign rd_data = mem[apipe[RL-1]];

   function automatic rec_t pixel_at(input int p, input bit m);
      rec_t r;
      int h, v, xs, ys;
      h = p % HT;
      v = (p / HT) % VT;
      xs = m ? h / 2 : h;
      ys = m ? v / 2 : v;
      r.act  = (h < HA) && (v < VA);
      r.hs   = !((h >= HA + HF) && (h < HA + HF + HS));
      r.vs   = !((v >= VA + VF) && (v < VA + VF + VS));
      r.addr = (FB + ys * (1 << XB) + xs) % (1 << AW);
      return r;
   endfunction

   function automatic logic [23:0] expand(input logic [15:0] d);
      int r5, g6, b5;
      r5 = int'(d[15:11]);
      g6 = int'(d[10:5]);
      b5 = int'(d[4:0]);
      return {8'((r5 << 3) | (r5 >> 2)), 8'((g6 << 2) | (g6 >> 4)), 8'((b5 << 3) | (b5 >> 2))};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s pos=%0d got=%h expected=%h", tag, n, got, exp);
      end
   endtask

   // One clk: drive inputs at negedge, check the model position, then advance it.
   task automatic tick(input bit pe, input bit sc, input bit rs);
      rec_t cur, o;
      bit   erq;
      logic [23:0] ergb;
      pix_en = pe;
      scale2x = sc;
      reset = rs;
      #1;
      cur = pixel_at(n, mode);
      erq = pe && !rs && cur.act;
      if (armed) begin
         if (n >= RL + 1) o = hist[n - RL - 1];
         else o = '{act: 1'b0, hs: 1'b1, vs: 1'b1, addr: 0};
         ergb = o.act ? expand(mem[o.addr]) : 24'h0;
         chk("rd_req", 32'(rd_req), 32'(erq));
         chk("rd_addr", 32'(rd_addr), erq ? cur.addr : last_addr);
         chk("frame_start", 32'(frame_start), 32'(pe && !rs && (n % FRAME == FRAME - 1)));
         chk("vga_hs", 32'(vga_hs), 32'(o.hs));
         chk("vga_vs", 32'(vga_vs), 32'(o.vs));
         chk("vga_blank_n", 32'(vga_blank_n), 32'(o.act));
         chk("vga_rgb", 32'({vga_r, vga_g, vga_b}), 32'(ergb));
      end
      @(posedge clk);
      if (rs) begin
         n = 0;
         last_addr = FB;
         mode = 1'b0;
         hist.delete();
         armed = 1'b1;
      end else if (pe) begin
         hist.push_back(cur);
         if (erq) last_addr = cur.addr;
         if (n % FRAME == 0) mode = sc;
         n++;
      end
      @(negedge clk);
   endtask

   initial begin
      n = 0; last_addr = FB; mode = 1'b0; armed = 1'b0;
      n_assert = 0; n_fail = 0;
      pix_en = 1'b1; scale2x = 1'b0; reset = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      mem[FB]     = 16'hF800;
      mem[FB + 1] = 16'h07E0;
      mem[FB + 2] = 16'h001F;
      mem[FB + 3] = 16'h0000;
      @(negedge clk);

      // reset held with pix_en high, then two full unscaled frames
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2 * FRAME + 10; i++) tick(1'b1, 1'b0, 1'b0);

      // scale2x raised mid-frame latches at the next frame start,
      // then dropped at line 3 of the scaled frame
      while (n % FRAME != 3 * HT) tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < FRAME + 2 * HT; i++) tick(1'b1, 1'b0, 1'b0);

      // pixel enable stalled for 37 clks in the middle of a line
      while (n % HT != 7) tick(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 37; i++) tick(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < FRAME; i++) tick(1'b1, 1'b1, 1'b0);

      // random pix_en and scale2x
      for (int i = 0; i < 3 * FRAME; i++)
         tick(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'b0);

      // reset mid-frame, then recover in scaled mode
      while (n % HT != 5) tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < FRAME + 20; i++) tick(1'b1, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
